// File: rtl/crypto_axis_tx.sv
// AXI-Stream transmitter for the chaos crypto engine: buffers processed beats and frames them with tlast/frame_done.
// Optional CRYPTO_TX_TUSER_EN adds m_axis_tuser marking the first beat of each frame.
module crypto_axis_tx #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cfg_load,
   input  logic [CNT_W-1:0]  frame_len,
   input  logic              soft_clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              m_axis_tvalid,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast,
`ifdef CRYPTO_TX_TUSER_EN
   output logic              m_axis_tuser,
`endif
   input  logic              m_axis_tready,
   output logic              busy,
   output logic              frame_done,
   output logic [CNT_W-1:0]  tx_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef CRYPTO_TX_TUSER_EN
   localparam int unsigned TAG_W = 2;
`else
   localparam int unsigned TAG_W = 1;
`endif
   localparam int unsigned ENT_W = DATA_W + TAG_W;
   localparam logic [AW:0]      PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
   logic [CNT_W-1:0]  len_q, in_cnt_q, tx_cnt_q;
   logic              frame_done_q;

   logic              fifo_full, fifo_empty, push, pop, push_last, head_last, cfg_ok;
   logic [ENT_W-1:0]  head, wr_entry;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign head_last  = head[DATA_W];
   assign push       = in_valid && in_ready;
   assign pop        = !fifo_empty && m_axis_tready;
   assign push_last  = (in_cnt_q == (len_q - CNT_ONE));
   assign cfg_ok     = (state_q == S_IDLE) && cfg_load && (frame_len != '0);

`ifdef CRYPTO_TX_TUSER_EN
   assign wr_entry     = {(in_cnt_q == '0), push_last, in_data};
   assign m_axis_tuser = !fifo_empty && head[DATA_W+1];
`else
   assign wr_entry     = {push_last, in_data};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (soft_clear) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:   if (cfg_ok)              state_d = S_STREAM;
            S_STREAM: if (push && push_last)   state_d = S_DRAIN;
            S_DRAIN:  if (pop && head_last)    state_d = S_IDLE;
            default:                           state_d = S_IDLE;
         endcase
      end
   end

   // in_ready depends only on registered state, never on m_axis_tready
   always_comb begin
      in_ready = (state_q == S_STREAM) && !fifo_full;
      busy     = (state_q != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         len_q        <= '0;
         in_cnt_q     <= '0;
         tx_cnt_q     <= '0;
         frame_done_q <= 1'b0;
      end else if (soft_clear) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         in_cnt_q     <= '0;
         tx_cnt_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= (state_q == S_DRAIN) && pop && head_last;
         if (cfg_ok) begin
            len_q    <= frame_len;
            in_cnt_q <= '0;
            tx_cnt_q <= '0;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            in_cnt_q <= in_cnt_q + CNT_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
         end
      end
   end

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_empty ? '0 : head[DATA_W-1:0];
   assign m_axis_tlast  = !fifo_empty && head_last;
   assign frame_done    = frame_done_q;
   assign tx_count      = tx_cnt_q;

endmodule
